// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter for N_REQ write requesters onto one registered register-file write port,
// with a flush sweep that zeroes every word and acknowledges on the final beat.
module rf_wport_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_REQ      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_REQ-1:0]                     req_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_wdata_i,
  output logic [N_REQ-1:0]                     gnt_o,
  input  logic                                 flush_req_i,
  output logic                                 flush_ack_o,
  output logic                                 busy_o,
  output logic                                 rf_we_o,
  output logic [ADDR_WIDTH-1:0]                rf_waddr_o,
  output logic [DATA_WIDTH-1:0]                rf_wdata_o
);

  localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam int unsigned PtrW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StFlush, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic [N_REQ-1:0]        arb_gnt;
  logic [PtrW-1:0]         arb_idx;
  logic                    arb_valid;
  logic [PtrW-1:0]         idx;

  // Rotating priority: first active requester at or after ptr_q wins.
  always_comb begin
    arb_gnt   = '0;
    arb_idx   = '0;
    arb_valid = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % N_REQ);
      if (!arb_valid && req_i[idx]) begin
        arb_valid    = 1'b1;
        arb_idx      = idx;
        arb_gnt[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        // Flush takes priority; pending requests simply wait it out.
        if (flush_req_i) begin
          state_d = StFlush;
          cnt_d   = '0;
        end else if (arb_valid) begin
          we_d    = 1'b1;
          waddr_d = req_addr_i[arb_idx];
          wdata_d = req_wdata_i[arb_idx];
          ptr_d   = PtrW'((32'(arb_idx) + 32'd1) % N_REQ);
        end
      end
      StFlush: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(NUM_WORDS - 1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status and grant are forced low while reset is held, regardless of state.
  always_comb begin
    gnt_o       = '0;
    busy_o      = rst_n && (state_q != StIdle);
    flush_ack_o = rst_n && (state_q == StDone);
    if (rst_n && (state_q == StIdle) && !flush_req_i) begin
      gnt_o = arb_gnt;
    end
  end

  assign rf_we_o    = we_q;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: table of single-cycle vectors plus hand-written
// sequences for fairness, flush sweep, collision, held flush and reset mid-flush.
module tb_rf_wport_arbiter;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req;
  logic [3:0][4:0]   addr;
  logic [3:0][31:0]  data;
  logic [3:0]        gnt;
  logic              flush_req;
  logic              flush_ack;
  logic              busy;
  logic              we;
  logic [4:0]        waddr;
  logic [31:0]       wdata;

  int n_cmp;
  int n_fail;

  rf_wport_arbiter #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .N_REQ      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .req_addr_i  (addr),
    .req_wdata_i (data),
    .gnt_o       (gnt),
    .flush_req_i (flush_req),
    .flush_ack_o (flush_ack),
    .busy_o      (busy),
    .rf_we_o     (we),
    .rf_waddr_o  (waddr),
    .rf_wdata_o  (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req       = 4'hF;
    flush_req = 1'b1;
    addr[0] = 5'd1;  data[0] = 32'h1111_1111;
    addr[1] = 5'd3;  data[1] = 32'h2222_2222;
    addr[2] = 5'd5;  data[2] = 32'hDEAD_BEEF;
    addr[3] = 5'd7;  data[3] = 32'h4444_4444;

    //             req      gnt      we    waddr  wdata
    tbl[0] = '{4'b0100, 4'b0100, 1'b0, 5'd0, 32'h0};
    tbl[1] = '{4'b0000, 4'b0000, 1'b1, 5'd5, 32'hDEAD_BEEF};
    tbl[2] = '{4'b0000, 4'b0000, 1'b0, 5'd5, 32'hDEAD_BEEF};
    tbl[3] = '{4'b0011, 4'b0001, 1'b0, 5'd5, 32'hDEAD_BEEF};
    tbl[4] = '{4'b0010, 4'b0010, 1'b1, 5'd1, 32'h1111_1111};
    tbl[5] = '{4'b1000, 4'b1000, 1'b1, 5'd3, 32'h2222_2222};
    tbl[6] = '{4'b1010, 4'b0010, 1'b1, 5'd7, 32'h4444_4444};
    tbl[7] = '{4'b0000, 4'b0000, 1'b1, 5'd3, 32'h2222_2222};
    tbl[8] = '{4'b0000, 4'b0000, 1'b0, 5'd3, 32'h2222_2222};

    // Outputs stay quiet while reset is held, even with requests and flush asserted.
    #1;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ack", 64'(flush_ack), 64'(0));
    tick();
    tick();
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_waddr", 64'(waddr), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    rst_n     = 1'b1;
    req       = 4'b0000;
    flush_req = 1'b0;

    for (int i = 0; i < 9; i++) begin
      req = tbl[i].req;
      #1;
      chk($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
      chk($sformatf("vec%0d_we", i), 64'(we), 64'(tbl[i].we));
      chk($sformatf("vec%0d_waddr", i), 64'(waddr), 64'(tbl[i].waddr));
      chk($sformatf("vec%0d_wdata", i), 64'(wdata), 64'(tbl[i].wdata));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(0));
      tick();
    end

    // Fairness from reset with all four requesting.
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
    req   = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("fair%0d_gnt", k), 64'(gnt), 64'(4'b0001 << (k % 4)));
      chk($sformatf("fair%0d_we", k), 64'(we), 64'(k > 0));
      if (k > 0) chk($sformatf("fair%0d_waddr", k), 64'(waddr), 64'(addr[(k - 1) % 4]));
      tick();
    end
    req = 4'b0000;
    #1;
    chk("fair_last_we", 64'(we), 64'(1));
    chk("fair_last_waddr", 64'(waddr), 64'(addr[3]));
    tick();

    // Flush colliding with a request; flush_req toggled mid-sweep must be ignored.
    flush_req = 1'b1;
    req       = 4'b0001;
    #1;
    chk("col_s_gnt", 64'(gnt), 64'(0));
    chk("col_s_busy", 64'(busy), 64'(0));
    tick();
    flush_req = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      if (k == 10) flush_req = 1'b1;
      if (k == 20) flush_req = 1'b0;
      #1;
      chk($sformatf("fl%0d_gnt", k), 64'(gnt), 64'(0));
      chk($sformatf("fl%0d_busy", k), 64'(busy), 64'(1));
      chk($sformatf("fl%0d_ack", k), 64'(flush_ack), 64'(k == 33));
      chk($sformatf("fl%0d_we", k), 64'(we), 64'(k >= 2));
      if (k >= 2) begin
        chk($sformatf("fl%0d_waddr", k), 64'(waddr), 64'(k - 2));
        chk($sformatf("fl%0d_wdata", k), 64'(wdata), 64'(0));
      end
      tick();
    end
    #1;
    chk("fl_idle_gnt", 64'(gnt), 64'(4'b0001));
    chk("fl_idle_busy", 64'(busy), 64'(0));
    chk("fl_idle_ack", 64'(flush_ack), 64'(0));
    chk("fl_idle_we", 64'(we), 64'(0));
    chk("fl_idle_waddr_hold", 64'(waddr), 64'(31));
    tick();
    req = 4'b0000;
    #1;
    chk("fl_post_we", 64'(we), 64'(1));
    chk("fl_post_waddr", 64'(waddr), 64'(addr[0]));
    chk("fl_post_wdata", 64'(wdata), 64'(data[0]));
    tick();

    // Held flush: a second sweep starts straight after DONE.
    flush_req = 1'b1;
    #1;
    chk("held_s_busy", 64'(busy), 64'(0));
    tick();
    for (int k = 1; k <= 33; k++) begin
      #1;
      chk($sformatf("hf%0d_busy", k), 64'(busy), 64'(1));
      chk($sformatf("hf%0d_ack", k), 64'(flush_ack), 64'(k == 33));
      if (k >= 2) chk($sformatf("hf%0d_waddr", k), 64'(waddr), 64'(k - 2));
      tick();
    end
    #1;
    chk("hf_idle_busy", 64'(busy), 64'(0));
    chk("hf_idle_ack", 64'(flush_ack), 64'(0));
    tick();
    flush_req = 1'b0;
    #1;
    chk("hf2_start_busy", 64'(busy), 64'(1));
    chk("hf2_start_we", 64'(we), 64'(0));
    tick();
    for (int m = 2; m <= 10; m++) begin
      #1;
      chk($sformatf("hf2_%0d_we", m), 64'(we), 64'(1));
      chk($sformatf("hf2_%0d_waddr", m), 64'(waddr), 64'(m - 2));
      tick();
    end

    // Reset while the sweep counter sits at 10.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ack", 64'(flush_ack), 64'(0));
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_post_we", 64'(we), 64'(0));
    chk("mid_post_busy", 64'(busy), 64'(0));
    chk("mid_post_ack", 64'(flush_ack), 64'(0));
    chk("mid_post_waddr", 64'(waddr), 64'(0));
    tick();
    req = 4'b1010;
    #1;
    chk("mid_req_gnt", 64'(gnt), 64'(4'b0010));
    tick();
    req = 4'b0000;
    #1;
    chk("mid_req_we", 64'(we), 64'(1));
    chk("mid_req_waddr", 64'(waddr), 64'(addr[1]));
    chk("mid_req_wdata", 64'(wdata), 64'(data[1]));
    tick();
    for (int k = 0; k < 30; k++) begin
      #1;
      chk($sformatf("quiet%0d_ack", k), 64'(flush_ack), 64'(0));
      chk($sformatf("quiet%0d_busy", k), 64'(busy), 64'(0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
